// File: rtl/dstk_ctrl_if.sv
// Interfaces of the data-stack controller: the decoder-facing command port
// and the stack bus into the EBR stack memory (stk_io).

interface dstk_cmd_if #(
  parameter int DSZ = 32,
  parameter int DW  = 7
);
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [2:0]     cmd;
  logic [DSZ-1:0] din;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] nos;
  logic [DW-1:0]  depth;
  logic           empty;
  logic           full;
  logic           err;

  modport master (
    output cmd_vld, cmd, din,
    input  cmd_rdy, tos, nos, depth, empty, full, err
  );

  modport slave (
    input  cmd_vld, cmd, din,
    output cmd_rdy, tos, nos, depth, empty, full, err
  );
endinterface

interface dstk_bus_if #(
  parameter int DSZ = 32
);
  logic [1:0]     s_op;
  logic           s_en;
  logic [DSZ-1:0] s_vi;
  logic [DSZ-1:0] s_vo;

  modport master (
    output s_op, s_en, s_vi,
    input  s_vo
  );

  modport slave (
    input  s_op, s_en, s_vi,
    output s_vo
  );
endinterface

// File: rtl/dstk_ctrl.sv
// Data-stack controller: TOS/NOS cached in registers, deeper entries spill
// to / fill from the stack memory. Define DSTK_GUARD_EN for under/overflow guarding.

module dstk_ctrl #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int DW    = $clog2(DEPTH + 3)
) (
  input  logic       clk,
  input  logic       rst,
  dstk_cmd_if.slave  c,
  dstk_bus_if.master b
);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PUSH = 3'd1,
    CMD_DROP = 3'd2,
    CMD_DUP  = 3'd3,
    CMD_SWAP = 3'd4,
    CMD_OVER = 3'd5,
    CMD_ROT  = 3'd6,
    CMD_REPL = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_READ = 2'd2
  } sop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam logic [DW-1:0] D_FULL  = DW'(DEPTH + 2);
  localparam logic [DW-1:0] D_ONE   = DW'(1);
  localparam logic [DW-1:0] D_TWO   = DW'(2);
  localparam logic [DW-1:0] D_THREE = DW'(3);

  state_e         state, state_nxt;
  logic [DSZ-1:0] tos, tos_nxt;
  logic [DSZ-1:0] nos, nos_nxt;
  logic [DW-1:0]  depth, depth_nxt;
  logic [DW-1:0]  depth_inc, depth_dec;
  logic           rot_pend, rot_pend_nxt;  // FILL completes a ROT, not a DROP

  sop_e           s_op;
  logic           s_en;
  logic [DSZ-1:0] s_vi;

  cmd_e           op;
  logic           go;
  logic           grows;
  logic           suppress;

  assign op        = cmd_e'(c.cmd);
  assign go        = c.cmd_vld && (state == ST_IDLE);
  assign grows     = (op == CMD_PUSH) || (op == CMD_DUP) || (op == CMD_OVER);
  assign depth_inc = (depth == D_FULL) ? depth : depth + D_ONE;
  assign depth_dec = (depth == '0)     ? depth : depth - D_ONE;

`ifdef DSTK_GUARD_EN
  logic [DW-1:0] min_depth;
  logic          err_q;

  always_comb begin
    min_depth = '0;
    case (op)
      CMD_DROP, CMD_REPL: min_depth = D_ONE;
      CMD_SWAP, CMD_OVER: min_depth = D_TWO;
      CMD_ROT:            min_depth = D_THREE;
      default:            min_depth = '0;
    endcase
  end

  // A bad command is still accepted so the core never stalls on it.
  assign suppress = (depth < min_depth) || (grows && (depth == D_FULL));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= go && suppress;
  end

  assign c.err = err_q;
`else
  assign suppress = 1'b0;
  assign c.err    = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt    = state;
    tos_nxt      = tos;
    nos_nxt      = nos;
    depth_nxt    = depth;
    rot_pend_nxt = rot_pend;
    s_op         = OP_READ;
    s_en         = 1'b0;
    s_vi         = '0;

    case (state)
      ST_IDLE: begin
        if (go && !suppress) begin
          // Once both cache registers hold live data, growing pushes NOS out.
          if (grows && (depth >= D_TWO)) begin
            s_op = OP_PUSH;
            s_en = 1'b1;
            s_vi = nos;
          end

          case (op)
            CMD_PUSH: begin
              nos_nxt   = tos;
              tos_nxt   = c.din;
              depth_nxt = depth_inc;
            end
            CMD_DUP: begin
              nos_nxt   = tos;
              depth_nxt = depth_inc;
            end
            CMD_OVER: begin
              nos_nxt   = tos;
              tos_nxt   = nos;
              depth_nxt = depth_inc;
            end
            CMD_SWAP: begin
              tos_nxt = nos;
              nos_nxt = tos;
            end
            CMD_REPL: begin
              tos_nxt = c.din;
            end
            CMD_DROP: begin
              tos_nxt = nos;
              if (depth >= D_THREE) begin
                s_op         = OP_POP;
                s_en         = 1'b1;
                state_nxt    = ST_FILL;
                rot_pend_nxt = 1'b0;
              end else begin
                depth_nxt = depth_dec;
              end
            end
            CMD_ROT: begin
              s_op         = OP_POP;
              s_en         = 1'b1;
              state_nxt    = ST_FILL;
              rot_pend_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_FILL: begin
        state_nxt = ST_IDLE;
        if (rot_pend) begin
          // The re-push of b and the sample of a share this edge; s_vo still
          // holds the popped value until the memory sees the push.
          s_op    = OP_PUSH;
          s_en    = 1'b1;
          s_vi    = nos;
          tos_nxt = b.s_vo;
          nos_nxt = tos;
        end else begin
          nos_nxt   = b.s_vo;
          depth_nxt = depth_dec;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= ST_IDLE;
      tos      <= '0;
      nos      <= '0;
      depth    <= '0;
      rot_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      tos      <= tos_nxt;
      nos      <= nos_nxt;
      depth    <= depth_nxt;
      rot_pend <= rot_pend_nxt;
    end
  end

  assign c.cmd_rdy = (state == ST_IDLE);
  assign c.tos     = tos;
  assign c.nos     = nos;
  assign c.depth   = depth;
  assign c.empty   = (depth == '0);
  assign c.full    = (depth == D_FULL);

  // The stack memory shares rst; keep the bus quiet while it is held.
  assign b.s_op = rst ? OP_READ : s_op;
  assign b.s_en = s_en && !rst;
  assign b.s_vi = rst ? '0 : s_vi;

endmodule

// File: tb/tb_dstk_ctrl.sv
// Self-checking bench for dstk_ctrl: directed stack scenarios plus randomized
// command streams checked against a queue-based stack model and a memory model.

module tb_dstk_ctrl;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int DW    = $clog2(DEPTH + 3);
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXD  = DEPTH + 2;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_PUSH = 3'd1;
  localparam logic [2:0] C_DROP = 3'd2;
  localparam logic [2:0] C_DUP  = 3'd3;
  localparam logic [2:0] C_SWAP = 3'd4;
  localparam logic [2:0] C_OVER = 3'd5;
  localparam logic [2:0] C_ROT  = 3'd6;
  localparam logic [2:0] C_REPL = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dstk_cmd_if #(.DSZ(DSZ), .DW(DW)) cif ();
  dstk_bus_if #(.DSZ(DSZ))          bif ();

  dstk_ctrl #(.DEPTH(DEPTH), .DSZ(DSZ), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .c   (cif),
    .b   (bif)
  );

  always #5 clk = ~clk;

  // Stack memory model: one-cycle registered read, shares rst with the DUT.
  logic [DSZ-1:0] mem [DEPTH];
  logic [AW-1:0]  sp;
  logic [DSZ-1:0] vo;
  logic [DSZ-1:0] last_pval = '0;
  int             n_push = 0;
  int             n_pop  = 0;

  always @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      vo <= '0;
    end else if (bif.s_en) begin
      if (bif.s_op == 2'd0) begin
        mem[sp]   <= bif.s_vi;
        sp        <= sp + 1'b1;
        n_push    <= n_push + 1;
        last_pval <= bif.s_vi;
      end else if (bif.s_op == 2'd1) begin
        vo    <= mem[sp - 1'b1];
        sp    <= sp - 1'b1;
        n_pop <= n_pop + 1;
      end
    end
  end

  assign bif.s_vo = vo;

  // Logical stack, bottom at index 0.
  logic [DSZ-1:0] mq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] op, input int n);
    int mind;
    case (op)
      C_DROP, C_REPL: mind = 1;
      C_SWAP, C_OVER: mind = 2;
      C_ROT:          mind = 3;
      default:        mind = 0;
    endcase
    if (n < mind) return 1'b0;
    if ((op == C_PUSH || op == C_DUP || op == C_OVER) && n == MAXD) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    check({tag, "_depth"}, cif.depth, n);
    check({tag, "_empty"}, cif.empty, n == 0);
    check({tag, "_full"},  cif.full,  n == MAXD);
    if (n >= 1) check({tag, "_tos"}, cif.tos, mq[n-1]);
    if (n >= 2) check({tag, "_nos"}, cif.nos, mq[n-2]);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic issue(input logic [2:0] op, input logic [DSZ-1:0] d);
    int n, mb, ma, p0, q0, exp_push, exp_pop;
    bit legal, two;
    logic [DSZ-1:0] t, exp_pv;
    n        = mq.size();
    legal    = is_legal(op, n);
    two      = legal && ((op == C_DROP && n >= 3) || op == C_ROT);
    p0       = n_push;
    q0       = n_pop;
    exp_push = 0;
    exp_pop  = 0;
    exp_pv   = last_pval;
    if (legal) begin
      mb = (n > 2) ? n - 2 : 0;
      case (op)
        C_PUSH: mq.push_back(d);
        C_DUP:  mq.push_back(mq[n-1]);
        C_OVER: mq.push_back(mq[n-2]);
        C_SWAP: begin t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t; end
        C_ROT:  begin t = mq[n-3]; mq.delete(n-3); mq.push_back(t); end
        C_DROP: void'(mq.pop_back());
        C_REPL: mq[n-1] = d;
        default: ;
      endcase
      ma = (mq.size() > 2) ? mq.size() - 2 : 0;
      if (ma > mb) exp_push = 1;
      if (ma < mb) exp_pop  = 1;
      if (op == C_ROT) begin exp_push = 1; exp_pop = 1; end
      if (exp_push != 0) exp_pv = mq[mq.size()-3];
    end

    check("rdy_before", cif.cmd_rdy, 1);
    cif.cmd_vld = 1'b1;
    cif.cmd     = op;
    cif.din     = d;
    @(negedge clk);
`ifdef DSTK_GUARD_EN
    check("err_pulse", cif.err, !legal);
`else
    check("err_pulse", cif.err, 0);
`endif
    check("rdy_after", cif.cmd_rdy, !two);
    if (two) begin
      // A command offered while not ready must be ignored.
      cif.cmd = C_PUSH;
      cif.din = $urandom;
      @(negedge clk);
      check("rdy_fill_done", cif.cmd_rdy, 1);
      check("err_clear", cif.err, 0);
    end
    cif.cmd_vld = 1'b0;
    check("bus_push_cnt", n_push - p0, exp_push);
    check("bus_pop_cnt",  n_pop - q0,  exp_pop);
    if (exp_push != 0) check("bus_push_val", last_pval, exp_pv);
    check_state("post");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tos"},   cif.tos, 0);
    check({tag, "_nos"},   cif.nos, 0);
    check({tag, "_depth"}, cif.depth, 0);
    check({tag, "_empty"}, cif.empty, 1);
    check({tag, "_full"},  cif.full, 0);
    check({tag, "_err"},   cif.err, 0);
    check({tag, "_rdy"},   cif.cmd_rdy, 1);
    check({tag, "_sop"},   bif.s_op, 2);
    check({tag, "_sen"},   bif.s_en, 0);
    check({tag, "_svi"},   bif.s_vi, 0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    cif.cmd_vld = 1'b0;
    cif.cmd     = C_NOP;
    cif.din     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [2:0] op;

    // Reset, then PUSH 1 2 3: one spill of 1 on the third accept.
    do_reset();
    check_reset_values("reset");
    p0 = n_push;
    issue(C_PUSH, 1);
    issue(C_PUSH, 2);
    issue(C_PUSH, 3);
    check("t123_tos", cif.tos, 3);
    check("t123_nos", cif.nos, 2);
    check("t123_depth", cif.depth, 3);
    check("t123_pushes", n_push - p0, 1);
    check("t123_pval", last_pval, 1);

    // DROP from 1 2 3.
    issue(C_DROP, 0);
    check("drop_tos", cif.tos, 2);
    check("drop_nos", cif.nos, 1);
    check("drop_depth", cif.depth, 2);

    // ROT from 1 2 3.
    do_reset();
    issue(C_PUSH, 1);
    issue(C_PUSH, 2);
    issue(C_PUSH, 3);
    issue(C_ROT, 0);
    check("rot_tos", cif.tos, 1);
    check("rot_nos", cif.nos, 3);
    check("rot_depth", cif.depth, 3);
    check("rot_pval", last_pval, 2);

    // 5 7, SWAP then OVER.
    do_reset();
    issue(C_PUSH, 5);
    issue(C_PUSH, 7);
    issue(C_SWAP, 0);
    check("swap_tos", cif.tos, 5);
    check("swap_nos", cif.nos, 7);
    issue(C_OVER, 0);
    check("over_tos", cif.tos, 7);
    check("over_nos", cif.nos, 5);
    check("over_depth", cif.depth, 3);
    check("over_pval", last_pval, 7);
    issue(C_REPL, 32'hdead_beef);
    issue(C_DUP, 0);

    // Reset during DROP's FILL cycle.
    do_reset();
    issue(C_PUSH, 1);
    issue(C_PUSH, 2);
    issue(C_PUSH, 3);
    cif.cmd_vld = 1'b1;
    cif.cmd     = C_DROP;
    @(negedge clk);
    check("rstfill_rdy_low", cif.cmd_rdy, 0);
    rst         = 1'b1;
    cif.cmd_vld = 1'b0;
    @(negedge clk);
    check_reset_values("rstfill");
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
    issue(C_PUSH, 4);
    check("rstfill_tos", cif.tos, 4);
    check("rstfill_depth", cif.depth, 1);

    // Fill to DEPTH+2.
    do_reset();
`ifdef DSTK_GUARD_EN
    issue(C_DROP, 0);
    check("uflow_depth", cif.depth, 0);
`endif
    for (int i = 0; i < MAXD; i++) issue(C_PUSH, $urandom);
    check("full_flag", cif.full, 1);
    check("full_depth", cif.depth, MAXD);
`ifdef DSTK_GUARD_EN
    issue(C_PUSH, 99);
    check("oflow_tos_kept", cif.tos, mq[mq.size()-1]);
`endif
    for (int i = 0; i < 20; i++) issue(C_DROP, 0);

    // Randomized command stream.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = C_PUSH;
`ifndef DSTK_GUARD_EN
      while (!is_legal(op, mq.size())) op = 3'($urandom_range(0, 7));
`endif
      issue(op, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
